// File: rtl/seg7_pkg.sv
// Shared constants and types for the serial 7-segment display driver.
package seg7_pkg;

    // Bit positions inside the 4-bit serial output bundle.
    localparam int SOUT_CLK = 3;
    localparam int SOUT_DO  = 2;
    localparam int SOUT_PEN = 1;
    localparam int SOUT_CLR = 0;

    // Fully dark digit, decimal point included (active low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bits per frame: 8 digits x 8 segment bits.
    localparam logic [6:0] FRAME_BITS = 7'd64;

    // Active-low {g,f,e,d,c,b,a} pattern for each hex nibble, entry 0 at the LSB end.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_if.sv
// Display-side bundle: digit value, decimal points, blink enables and the serial pins.
interface seg7_if;
    logic [31:0] data;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic [3:0]  sout;

    // Game/score logic side.
    modport master (output data, point, LES, input sout);
    // Display driver side.
    modport slave  (input data, point, LES, output sout);
endinterface

// File: rtl/seg7_hex_decode.sv
// One digit: nibble + decimal point + blank request -> active-low segment byte.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // Blanking overrides everything, including the decimal point.
    always_comb begin
        seg_o = {~dp_i, HEX_SEG[nibble_i]};
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_device.sv
// Serial driver for the 8-digit display: builds a 64-bit frame, shifts it out MSB
// first with a divided clock, then pulses the latch enable and repeats.
module seg7_device
    import seg7_pkg::*;
#(
    parameter int unsigned IO_DIV    = 8,
    parameter int unsigned HOLD      = 128,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic    clk,
    input  logic    rst,
    seg7_if.slave   bus
);

    seg7_state_e state_q, state_d;

    logic [63:0] frame;
    logic [63:0] shift_q, shift_d;
    logic [31:0] div_cnt_q, div_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic        sclk_q, sclk_d;
    logic        sdo_q, sdo_d;
    logic        pen_q, pen_d;
    logic        clr_q;
    logic [31:0] blink_cnt_q;
    logic        blink_q;

    logic div_last;
    logic hold_last;

    assign div_last  = (div_cnt_q == IO_DIV - 1);
    assign hold_last = (hold_cnt_q == HOLD - 1);

    // Live frame from the current inputs; only sampled in LOAD so frames never tear.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            seg7_hex_decode u_dec (
                .nibble_i (bus.data[4*gi +: 4]),
                .dp_i     (bus.point[gi]),
                .blank_i  (blink_q & bus.LES[gi]),
                .seg_o    (frame[8*gi +: 8])
            );
        end
    endgenerate

    // Free-running blink phase; LOAD sees the pre-toggle value on a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_DIV - 1) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave SHIFT on the falling serial-clock edge after the 64th rise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    state_d = SHIFT;
            SHIFT:   if (div_last && sclk_q && (bit_cnt_q == FRAME_BITS)) state_d = LATCH;
            LATCH:   if (hold_last) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Output/datapath next values; DO only moves together with a falling serial clock.
    always_comb begin
        shift_d    = shift_q;
        div_cnt_d  = div_cnt_q;
        hold_cnt_d = hold_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        pen_d      = pen_q;
        unique case (state_q)
            LOAD: begin
                shift_d   = frame;
                sclk_d    = 1'b0;
                sdo_d     = frame[63];
                pen_d     = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
            end
            SHIFT: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == FRAME_BITS) begin
                            sdo_d      = 1'b0;
                            pen_d      = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            shift_d = {shift_q[62:0], 1'b0};
                            sdo_d   = shift_q[62];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
            LATCH: begin
                if (hold_last) begin
                    pen_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: begin
                pen_d = 1'b0;
            end
        endcase
    end

    // Datapath and pin registers; CLR releases on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            div_cnt_q  <= '0;
            hold_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            pen_q      <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            div_cnt_q  <= div_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            sdo_q      <= sdo_d;
            pen_q      <= pen_d;
            clr_q      <= 1'b1;
        end
    end

    always_comb begin
        bus.sout           = '0;
        bus.sout[SOUT_CLK] = sclk_q;
        bus.sout[SOUT_DO]  = sdo_q;
        bus.sout[SOUT_PEN] = pen_q;
        bus.sout[SOUT_CLR] = clr_q;
    end

endmodule

// File: tb/tb_seg7_device.sv
// Scoreboard bench: a timing-level model predicts each frame at its LOAD edge,
// a pin monitor reassembles frames from the serial stream and compares.
module tb_seg7_device;

    localparam int IO_DIV    = 2;
    localparam int HOLD      = 4;
    localparam int BLINK_DIV = 300;
    localparam int FRAME_LEN = 1 + 128 * IO_DIV + HOLD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg7_if bus ();

    seg7_device #(
        .IO_DIV    (IO_DIV),
        .HOLD      (HOLD),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_n  = 0;
    int frames_seen = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [63:0] ref_frame(input logic [31:0] d, input logic [7:0] p,
                                              input logic [7:0] l, input bit ph);
        logic [63:0] f;
        logic [7:0]  b;
        f = '0;
        for (int i = 7; i >= 0; i--) begin
            if (ph && l[i]) b = 8'hFF;
            else            b = {~p[i], hex7(d[4*i +: 4])};
            f = {f[55:0], b};
        end
        return f;
    endfunction

    // Reference model: LOAD happens every FRAME_LEN edges after reset release,
    // blink phase is the number of completed BLINK_DIV periods, modulo 2.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_n = 0;
                exp_q.delete();
            end else begin
                if (model_n % FRAME_LEN == 0)
                    exp_q.push_back(ref_frame(bus.data, bus.point, bus.LES,
                                              ((model_n / BLINK_DIV) % 2) == 1));
                model_n++;
            end
        end
    end

    // Pin monitor, sampled on the falling system clock.
    initial begin
        logic [3:0]  prev, cur;
        logic [63:0] cap, e;
        int bits, pen_cnt, since_fall;
        bit fall_seen, viol;
        prev = '0; cap = '0; bits = 0; pen_cnt = 0; since_fall = 0; fall_seen = 0; viol = 0;
        forever begin
            @(negedge clk);
            cur = bus.sout;
            if (rst) begin
                bits = 0; pen_cnt = 0; since_fall = 0; fall_seen = 0; viol = 0;
                prev = cur;
                continue;
            end
            since_fall++;
            if (!prev[3] && cur[3]) begin
                cap = {cap[62:0], cur[2]};
                bits++;
            end
            if (prev[3] && cur[3] && (prev[2] != cur[2])) viol = 1;
            if (cur[1] && cur[3]) viol = 1;
            if (cur[1]) pen_cnt++;
            if (!prev[1] && cur[1]) begin
                frames_seen++;
                chk("bit_count", bits, 64);
                chk("protocol", viol, 0);
                chk("clr_high", cur[0], 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_data actual=%0h expected=none_queued", cap);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", cap, e);
                    $display("frame %0d got=%016h exp=%016h", frames_seen, cap, e);
                end
                bits = 0;
                viol = 0;
            end
            if (prev[1] && !cur[1]) begin
                chk("pen_width", pen_cnt, HOLD);
                if (fall_seen) chk("frame_period", since_fall, FRAME_LEN);
                fall_seen = 1;
                since_fall = 0;
                pen_cnt = 0;
            end
            prev = cur;
        end
    end

    task automatic drive(input logic [31:0] d, input logic [7:0] p, input logic [7:0] l);
        @(negedge clk);
        #2;
        bus.data  = d;
        bus.point = p;
        bus.LES   = l;
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME_LEN) @(negedge clk);
    endtask

    task automatic wait_offset(input int off);
        int k;
        k = 0;
        while ((model_n % FRAME_LEN) != off && k < 2 * FRAME_LEN) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2 * FRAME_LEN) begin
            checks++;
            failures++;
            $display("FAIL wait_offset actual=timeout expected=%0d", off);
        end
    endtask

    initial begin
        bus.data  = 32'h0123_4567;
        bus.point = 8'h00;
        bus.LES   = 8'h00;

        // Power-on reset: outputs drop asynchronously.
        #1 rst = 1'b1;
        #1 chk("reset_sout", bus.sout, 4'b0000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("clr_after_reset", bus.sout[0], 1'b1);

        // Plain hex frames, then decimal points.
        run_frames(2);
        drive(32'hFFFF_FFFF, 8'h81, 8'h00);
        run_frames(2);

        // Blink on digit 1 across both phases.
        drive(32'h8888_8888, 8'h00, 8'h02);
        run_frames(4);

        // Data switched in the middle of bit 20: current frame keeps the old value.
        drive(32'h0000_0000, 8'h00, 8'h00);
        wait_offset(1 + 20 * 2 * IO_DIV + 1);
        #2 bus.data = 32'hFFFF_FFFF;
        run_frames(2);

        // Random inputs changing at random points in the frame.
        for (int i = 0; i < 8; i++) begin
            drive($urandom, 8'($urandom), 8'($urandom));
            repeat ($urandom_range(400, 50)) @(negedge clk);
        end

        // Reset during bit 30 aborts the frame at once.
        wait_offset(1 + 30 * 2 * IO_DIV + 1);
        #2 rst = 1'b1;
        #1 chk("reset_mid_shift", bus.sout, 4'b0000);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("clr_after_mid_reset", bus.sout[0], 1'b1);
        run_frames(3);
        repeat (10) @(negedge clk);

        chk("frames_seen_min", frames_seen >= 12, 1);
        chk("queue_drained", exp_q.size() <= 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
